// File: rtl/ifu_rd_responder.sv
// Read-only program memory at the slave end of the ifu AR/R channel.
// Returns one range/alignment/protection-checked R beat per AR request after LAT cycles.
module ifu_rd_responder #(
  parameter int          AW    = 64,
  parameter int          DW    = 64,
  parameter int          DEPTH = 4096,
  parameter logic [63:0] BASE  = 64'h8000_0000,
  parameter int          LAT   = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ifu_ARVALID,
  output logic                     ifu_ARREADY,
  input  logic [AW-1:0]            ifu_ARADDR,
  input  logic [2:0]               ifu_ARPORT,
  output logic                     ifu_RVALID,
  input  logic                     ifu_RREADY,
  output logic [DW-1:0]            ifu_RDATA,
  output logic [1:0]               ifu_RRESP,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [63:0]              ld_data
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [AW-1:0] BASE_A   = AW'(BASE);
  localparam logic [AW-1:0] SPAN     = AW'(DEPTH) << 3;
  localparam logic [3:0]    LAT_LAST = 4'(LAT - 1);
  // With a one-cycle latency the wait state is skipped entirely.
  localparam logic [1:0]    AR_START = (LAT == 1) ? RESP : WAIT;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [3:0]    cnt_reg;
  logic [3:0]    cnt_next;
  logic          ar_hs;
  logic          r_hs;

  logic [AW-1:0] off;
  logic          in_range;
  logic [1:0]    resp_new;
  logic [IW-1:0] rd_idx;

  logic [63:0]   mem [DEPTH];
  logic [63:0]   word_reg;
  logic          hi_reg;
  logic          ok_reg;
  logic [1:0]    rresp_reg;
  logic [31:0]   half;
  logic          ld_ok;
  logic          port_unused;

  assign ifu_ARREADY = rstn & ((state_reg == IDLE) | ((state_reg == RESP) & ifu_RREADY));
  assign ifu_RVALID  = (state_reg == RESP);
  assign ar_hs       = ifu_ARVALID & ifu_ARREADY;
  assign r_hs        = ifu_RVALID & ifu_RREADY;

  // Only the instruction-access bit of the protection field matters here.
  assign port_unused = ^ifu_ARPORT[1:0];

  assign off      = ifu_ARADDR - BASE_A;
  assign in_range = (ifu_ARADDR >= BASE_A) && (off < SPAN);
  assign rd_idx   = off[IW+2:3];

  always_comb begin
    resp_new = RESP_OKAY;
    if (!in_range) begin
      resp_new = RESP_DECERR;
    end else if ((ifu_ARADDR[1:0] != 2'b00) || !ifu_ARPORT[2]) begin
      resp_new = RESP_SLVERR;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (ar_hs) begin
          state_next = AR_START;
          cnt_next   = 4'd0;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_next == LAT_LAST) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (r_hs) begin
          if (ar_hs) begin
            state_next = AR_START;
            cnt_next   = 4'd0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      ok_reg    <= 1'b0;
      hi_reg    <= 1'b0;
      rresp_reg <= RESP_OKAY;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (ar_hs) begin
        rresp_reg <= resp_new;
        ok_reg    <= (resp_new == RESP_OKAY);
        hi_reg    <= ifu_ARADDR[2];
      end
    end
  end

  generate
    if (DEPTH == (2 ** IW)) begin : g_ld_full
      assign ld_ok = 1'b1;
    end else begin : g_ld_check
      localparam logic [IW:0] DEPTH_W = DEPTH[IW:0];
      assign ld_ok = ({1'b0, ld_idx} < DEPTH_W);
    end
  endgenerate

  // Read-before-write: a backdoor write at the handshake edge leaves the captured word old.
  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) begin
      mem[ld_idx] <= ld_data;
    end
    if (ar_hs) begin
      word_reg <= mem[rd_idx];
    end
  end

  assign half      = hi_reg ? word_reg[63:32] : word_reg[31:0];
  assign ifu_RDATA = ok_reg ? DW'(half) : '0;
  assign ifu_RRESP = rresp_reg;

endmodule

// File: tb/tb_ifu_rd_responder.sv
// Directed bench for ifu_rd_responder: one LAT=2 instance and one LAT=1 instance
// sharing clock, reset and backdoor load port.
module tb_ifu_rd_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ld_en;
  logic [11:0] ld_idx;
  logic [63:0] ld_data;

  logic        a_arvalid, a_arready, a_rvalid, a_rready;
  logic [63:0] a_araddr, a_rdata;
  logic [2:0]  a_arport;
  logic [1:0]  a_rresp;

  logic        b_arvalid, b_arready, b_rvalid, b_rready;
  logic [63:0] b_araddr, b_rdata;
  logic [2:0]  b_arport;
  logic [1:0]  b_rresp;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ifu_rd_responder #(.LAT(2)) dut_a (
    .clk(clk), .rstn(rstn),
    .ifu_ARVALID(a_arvalid), .ifu_ARREADY(a_arready), .ifu_ARADDR(a_araddr), .ifu_ARPORT(a_arport),
    .ifu_RVALID(a_rvalid), .ifu_RREADY(a_rready), .ifu_RDATA(a_rdata), .ifu_RRESP(a_rresp),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  ifu_rd_responder #(.LAT(1)) dut_b (
    .clk(clk), .rstn(rstn),
    .ifu_ARVALID(b_arvalid), .ifu_ARREADY(b_arready), .ifu_ARADDR(b_araddr), .ifu_ARPORT(b_arport),
    .ifu_RVALID(b_rvalid), .ifu_RREADY(b_rready), .ifu_RDATA(b_rdata), .ifu_RRESP(b_rresp),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  task automatic load_word(input logic [11:0] idx, input logic [63:0] data);
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Single read on instance A; lat counts cycles from the AR handshake edge to RVALID.
  task automatic a_read(input logic [63:0] addr, input logic [2:0] port,
                        output logic [63:0] data, output logic [1:0] resp, output int lat);
    int n;
    a_arvalid = 1'b1; a_araddr = addr; a_arport = port; a_rready = 1'b1;
    n = 0;
    while (!a_arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    a_arvalid = 1'b0;
    lat = 1;
    while (!a_rvalid && lat < 20) begin @(negedge clk); lat++; end
    data = a_rdata;
    resp = a_rresp;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    a_arvalid = 1'b0; a_araddr = '0; a_arport = 3'b100; a_rready = 1'b0;
    b_arvalid = 1'b0; b_araddr = '0; b_arport = 3'b100; b_rready = 1'b0;
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    @(negedge clk); @(negedge clk);
    vectors++; if (a_arready !== 1'b0) begin miscompares++; $display("FAIL reset_arready: got %b expected 0", a_arready); end
    vectors++; if (a_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b expected 0", a_rvalid); end
    vectors++; if (a_rdata !== 64'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0", a_rdata); end
    vectors++; if (a_rresp !== 2'b00) begin miscompares++; $display("FAIL reset_rresp: got %b expected 00", a_rresp); end
    rstn = 1'b1;
    #1;
    vectors++; if (a_arready !== 1'b1) begin miscompares++; $display("FAIL release_arready: got %b expected 1", a_arready); end
    @(negedge clk);
    vectors++; if (b_rvalid !== 1'b0) begin miscompares++; $display("FAIL release_rvalid_b: got %b expected 0", b_rvalid); end
  endtask

  task automatic test_basic();
    logic [63:0] d; logic [1:0] r; int l;
    a_read(BASE, 3'b100, d, r, l);
    vectors++; if (l !== 2) begin miscompares++; $display("FAIL basic_latency: got %0d expected 2", l); end
    vectors++; if (d !== 64'h0000_0013) begin miscompares++; $display("FAIL basic_lo_data: got %h expected 13", d); end
    vectors++; if (r !== 2'b00) begin miscompares++; $display("FAIL basic_lo_resp: got %b expected 00", r); end
    a_read(BASE + 64'h4, 3'b100, d, r, l);
    vectors++; if (d !== 64'h0010_0093) begin miscompares++; $display("FAIL basic_hi_data: got %h expected 00100093", d); end
    vectors++; if (r !== 2'b00) begin miscompares++; $display("FAIL basic_hi_resp: got %b expected 00", r); end
    vectors++; if (a_rvalid !== 1'b0) begin miscompares++; $display("FAIL basic_rvalid_drop: got %b expected 0", a_rvalid); end
  endtask

  task automatic test_errors();
    logic [63:0] addr_t [7];
    logic [2:0]  port_t [7];
    logic [1:0]  resp_t [7];
    logic [63:0] data_t [7];
    logic [63:0] d; logic [1:0] r; int l;
    addr_t = '{64'h7FFF_FFFC, 64'h8000_0002, 64'h8000_0000, 64'h8000_8000,
               64'h8000_7FFC, 64'h8000_7FF8, 64'hFFFF_FFFF_8000_0000};
    port_t = '{3'b100, 3'b100, 3'b000, 3'b100, 3'b100, 3'b111, 3'b100};
    resp_t = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b11};
    data_t = '{64'h0, 64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF, 64'h0BAD_F00D, 64'h0};
    for (int i = 0; i < 7; i++) begin
      a_read(addr_t[i], port_t[i], d, r, l);
      vectors++;
      if (r !== resp_t[i]) begin
        miscompares++; $display("FAIL err_resp[%0d] addr %h: got %b expected %b", i, addr_t[i], r, resp_t[i]);
      end
      vectors++;
      if (d !== data_t[i]) begin
        miscompares++; $display("FAIL err_data[%0d] addr %h: got %h expected %h", i, addr_t[i], d, data_t[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_t [8];
    exp_t = '{64'h0000_0013, 64'h0010_0093, 64'h1111_1111, 64'h2222_2222,
              64'h3333_3333, 64'h4444_4444, 64'h5555_5555, 64'h6666_6666};
    b_rready = 1'b1; b_arport = 3'b100;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin
        vectors++; if (b_rvalid !== 1'b1) begin miscompares++; $display("FAIL b2b_rvalid[%0d]: got %b expected 1", c - 1, b_rvalid); end
        vectors++; if (b_rdata !== exp_t[c-1]) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h expected %h", c - 1, b_rdata, exp_t[c-1]); end
        vectors++; if (b_rresp !== 2'b00) begin miscompares++; $display("FAIL b2b_resp[%0d]: got %b expected 00", c - 1, b_rresp); end
      end
      if (c < 8) begin
        vectors++; if (b_arready !== 1'b1) begin miscompares++; $display("FAIL b2b_arready[%0d]: got %b expected 1", c, b_arready); end
        b_arvalid = 1'b1;
        b_araddr  = BASE + 64'(4 * c);
      end else begin
        b_arvalid = 1'b0;
      end
      @(negedge clk);
    end
    vectors++; if (b_rvalid !== 1'b0) begin miscompares++; $display("FAIL b2b_end_rvalid: got %b expected 0", b_rvalid); end
  endtask

  task automatic test_backpressure();
    int n;
    a_rready = 1'b0; a_arvalid = 1'b1; a_araddr = BASE + 64'h4; a_arport = 3'b100;
    @(negedge clk);
    a_arvalid = 1'b0;
    n = 0;
    while (!a_rvalid && n < 20) begin @(negedge clk); n++; end
    vectors++; if (n >= 20) begin miscompares++; $display("FAIL bp_timeout: got no RVALID expected RVALID within 20 cycles"); end
    for (int c = 0; c < 3; c++) begin
      vectors++; if (a_rvalid !== 1'b1) begin miscompares++; $display("FAIL bp_rvalid[%0d]: got %b expected 1", c, a_rvalid); end
      vectors++; if (a_rdata !== 64'h0010_0093) begin miscompares++; $display("FAIL bp_data[%0d]: got %h expected 00100093", c, a_rdata); end
      vectors++; if (a_rresp !== 2'b00) begin miscompares++; $display("FAIL bp_resp[%0d]: got %b expected 00", c, a_rresp); end
      vectors++; if (a_arready !== 1'b0) begin miscompares++; $display("FAIL bp_arready[%0d]: got %b expected 0", c, a_arready); end
      @(negedge clk);
    end
    a_rready = 1'b1;
    #1;
    vectors++; if (a_rdata !== 64'h0010_0093) begin miscompares++; $display("FAIL bp_accept_data: got %h expected 00100093", a_rdata); end
    vectors++; if (a_arready !== 1'b1) begin miscompares++; $display("FAIL bp_accept_arready: got %b expected 1", a_arready); end
    @(negedge clk);
    vectors++; if (a_rvalid !== 1'b0) begin miscompares++; $display("FAIL bp_after_rvalid: got %b expected 0", a_rvalid); end
  endtask

  task automatic test_reset_midflight();
    logic [63:0] d; logic [1:0] r; int l;
    a_rready = 1'b1; a_arvalid = 1'b1; a_araddr = BASE + 64'h8; a_arport = 3'b100;
    @(negedge clk);
    a_arvalid = 1'b0;
    vectors++; if (a_rvalid !== 1'b0) begin miscompares++; $display("FAIL mid_wait_rvalid: got %b expected 0", a_rvalid); end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++; if (a_rvalid !== 1'b0) begin miscompares++; $display("FAIL mid_rvalid[%0d]: got %b expected 0", c, a_rvalid); end
      vectors++; if (a_arready !== 1'b1) begin miscompares++; $display("FAIL mid_arready[%0d]: got %b expected 1", c, a_arready); end
    end
    a_read(BASE + 64'hC, 3'b100, d, r, l);
    vectors++; if (l !== 2) begin miscompares++; $display("FAIL mid_next_latency: got %0d expected 2", l); end
    vectors++; if (d !== 64'h2222_2222) begin miscompares++; $display("FAIL mid_next_data: got %h expected 22222222", d); end
    vectors++; if (r !== 2'b00) begin miscompares++; $display("FAIL mid_next_resp: got %b expected 00", r); end
  endtask

  task automatic test_ld_collision();
    logic [63:0] d; logic [1:0] r; int l; int n;
    vectors++; if (a_arready !== 1'b1) begin miscompares++; $display("FAIL coll_arready: got %b expected 1", a_arready); end
    ld_en = 1'b1; ld_idx = 12'd0; ld_data = 64'hAAAA_BBBB_CCCC_DDDD;
    a_arvalid = 1'b1; a_araddr = BASE; a_arport = 3'b100; a_rready = 1'b1;
    @(negedge clk);
    ld_en = 1'b0; a_arvalid = 1'b0;
    n = 0;
    while (!a_rvalid && n < 20) begin @(negedge clk); n++; end
    vectors++; if (a_rdata !== 64'h0000_0013) begin miscompares++; $display("FAIL coll_old_data: got %h expected 13", a_rdata); end
    vectors++; if (a_rresp !== 2'b00) begin miscompares++; $display("FAIL coll_old_resp: got %b expected 00", a_rresp); end
    @(negedge clk);
    a_read(BASE, 3'b100, d, r, l);
    vectors++; if (d !== 64'hCCCC_DDDD) begin miscompares++; $display("FAIL coll_new_lo: got %h expected ccccdddd", d); end
    a_read(BASE + 64'h4, 3'b100, d, r, l);
    vectors++; if (d !== 64'hAAAA_BBBB) begin miscompares++; $display("FAIL coll_new_hi: got %h expected aaaabbbb", d); end
  endtask

  initial begin
    test_reset();
    load_word(12'd0, 64'h0010_0093_0000_0013);
    load_word(12'd1, 64'h2222_2222_1111_1111);
    load_word(12'd2, 64'h4444_4444_3333_3333);
    load_word(12'd3, 64'h6666_6666_5555_5555);
    load_word(12'd4095, 64'hDEAD_BEEF_0BAD_F00D);
    test_basic();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_ld_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
